// File: rtl/rc5_pkg.sv
// rc5_pkg -- shared definitions for the RC5 block engine.
//   rc5_state_e    : engine state encoding
//   MODE_DEC/ENC   : values of the iMode input
//   rc5_w_legal()  : true for the supported word widths (16, 32, 64)
package rc5_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_W,
        ST_WHITE,
        ST_RD,
        ST_H1,
        ST_H2,
        ST_DONE
    } rc5_state_e;

    localparam logic MODE_DEC = 1'b0;
    localparam logic MODE_ENC = 1'b1;

    function automatic bit rc5_w_legal(input int unsigned w);
        return (w == 16) || (w == 32) || (w == 64);
    endfunction

endpackage

// File: rtl/rc5_crypt_engine_rotator.sv
// rc5_rotator -- combinational barrel rotate.
//   iData   [W-1:0]  word to rotate
//   iRotate [RW-1:0] rotate amount
//   iDir             0 = rotate left, 1 = rotate right
//   oData   [W-1:0]  rotated word
module rc5_rotator #(
    parameter int unsigned W  = 32,
    parameter int unsigned RW = $clog2(W)
) (
    input  logic [W-1:0]  iData,
    input  logic [RW-1:0] iRotate,
    input  logic          iDir,
    output logic [W-1:0]  oData
);

    // Rotating within a doubled word turns the wrap-around into a plain shift.
    logic [2*W-1:0] dbl;

    always_comb begin
        if (iDir) begin
            dbl   = {iData, iData} >> iRotate;
            oData = dbl[W-1:0];
        end else begin
            dbl   = {iData, iData} << iRotate;
            oData = dbl[2*W-1:W];
        end
    end

endmodule

// File: rtl/rc5_crypt_engine.sv
// rc5_crypt_engine -- RC5-W/R block engine, one (A,B) pair per transaction.
// The expanded key S[0..2R+1] lives in an external registered RAM read through
// two address ports (even / odd index) with one cycle of latency.
//   clk, rst                  clock (rising edge), asynchronous active-low reset
//   iValid/oReady             input handshake; iMode (0 dec, 1 enc), iA, iB
//   oS_address1/oS_address2   S-table read addresses (even / odd index)
//   iS_sub_i1/iS_sub_i2       S-table read data
//   oValid/iReady             output handshake; oA, oB result words
// Build option: RC5_ENCRYPT_EN enables encryption; without it the engine is
// decrypt-only, iMode is ignored and the encrypt datapath is absent.
module rc5_crypt_engine
    import rc5_pkg::*;
#(
    parameter int unsigned W        = 32,
    parameter int unsigned R        = 12,
    parameter int unsigned RW       = $clog2(W),
    parameter int unsigned T_LENGTH = $clog2(2 * R + 2)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                iValid,
    output logic                oReady,
    input  logic                iMode,
    input  logic [W-1:0]        iA,
    input  logic [W-1:0]        iB,
    output logic [T_LENGTH-1:0] oS_address1,
    output logic [T_LENGTH-1:0] oS_address2,
    input  logic [W-1:0]        iS_sub_i1,
    input  logic [W-1:0]        iS_sub_i2,
    output logic                oValid,
    input  logic                iReady,
    output logic [W-1:0]        oA,
    output logic [W-1:0]        oB
);

    localparam int unsigned   CW       = $clog2(R + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(R);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    if (!rc5_w_legal(W)) begin : g_bad_w
        $error("rc5_crypt_engine: W must be 16, 32 or 64");
    end
    if (R < 1 || R > 255) begin : g_bad_r
        $error("rc5_crypt_engine: R must be in 1..255");
    end

    rc5_state_e          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [W-1:0]        a_q, a_d;
    logic [W-1:0]        b_q, b_d;
    logic [T_LENGTH-1:0] addr1_q, addr1_d;
    logic [T_LENGTH-1:0] addr2_q, addr2_d;

    logic enc_req;   // mode requested by the pair being accepted
    logic enc_act;   // mode of the transaction in flight

    logic [W-1:0]  rot_in, rot_out;
    logic [RW-1:0] rot_amt;
    logic          rot_dir;

    function automatic logic [T_LENGTH-1:0] even_addr(input logic [CW-1:0] idx);
        return T_LENGTH'({idx, 1'b0});
    endfunction

    function automatic logic [T_LENGTH-1:0] odd_addr(input logic [CW-1:0] idx);
        return T_LENGTH'({idx, 1'b1});
    endfunction

`ifdef RC5_ENCRYPT_EN
    logic mode_q, mode_d;

    always_comb begin
        mode_d = mode_q;
        if (state_q == ST_IDLE && iValid) begin
            mode_d = iMode;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q <= MODE_DEC;
        end else begin
            mode_q <= mode_d;
        end
    end

    assign enc_req = (iMode == MODE_ENC);
    assign enc_act = (mode_q == MODE_ENC);
`else
    logic unused_mode;
    assign unused_mode = iMode;
    assign enc_req     = 1'b0;
    assign enc_act     = 1'b0;
`endif

    rc5_rotator #(.W(W), .RW(RW)) u_rot (
        .iData   (rot_in),
        .iRotate (rot_amt),
        .iDir    (rot_dir),
        .oData   (rot_out)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        addr1_d = addr1_q;
        addr2_d = addr2_q;
        rot_in  = '0;
        rot_amt = '0;
        rot_dir = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (iValid) begin
                    a_d = iA;
                    b_d = iB;
                    if (enc_req) begin
                        cnt_d   = '0;
                        addr1_d = even_addr('0);
                        addr2_d = odd_addr('0);
                        state_d = ST_RD_W;
                    end else begin
                        cnt_d   = CNT_LAST;
                        addr1_d = even_addr(CNT_LAST);
                        addr2_d = odd_addr(CNT_LAST);
                        state_d = ST_RD;
                    end
                end
            end

            ST_RD_W: state_d = ST_WHITE;

            ST_RD: state_d = ST_H1;

            ST_WHITE: begin
                if (enc_act) begin
                    a_d     = a_q + iS_sub_i1;
                    b_d     = b_q + iS_sub_i2;
                    cnt_d   = CNT_ONE;
                    addr1_d = even_addr(CNT_ONE);
                    addr2_d = odd_addr(CNT_ONE);
                    state_d = ST_RD;
                end else begin
                    a_d     = a_q - iS_sub_i1;
                    b_d     = b_q - iS_sub_i2;
                    state_d = ST_DONE;
                end
            end

            // The single rotator serves both half-rounds; only its operands
            // and direction change between H1 and H2.
            ST_H1: begin
                if (enc_act) begin
                    rot_in  = a_q ^ b_q;
                    rot_amt = b_q[RW-1:0];
                    rot_dir = 1'b0;
                    a_d     = rot_out + iS_sub_i1;
                end else begin
                    rot_in  = b_q - iS_sub_i2;
                    rot_amt = a_q[RW-1:0];
                    rot_dir = 1'b1;
                    b_d     = rot_out ^ a_q;
                end
                state_d = ST_H2;
            end

            ST_H2: begin
                if (enc_act) begin
                    rot_in  = b_q ^ a_q;
                    rot_amt = a_q[RW-1:0];
                    rot_dir = 1'b0;
                    b_d     = rot_out + iS_sub_i2;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        addr1_d = even_addr(cnt_d);
                        addr2_d = odd_addr(cnt_d);
                        state_d = ST_RD;
                    end
                end else begin
                    rot_in  = a_q - iS_sub_i1;
                    rot_amt = b_q[RW-1:0];
                    rot_dir = 1'b1;
                    a_d     = rot_out ^ b_q;
                    if (cnt_q == CNT_ONE) begin
                        // Last decrypt round: fetch S0/S1 for the final un-whitening.
                        cnt_d   = '0;
                        addr1_d = even_addr('0);
                        addr2_d = odd_addr('0);
                        state_d = ST_RD_W;
                    end else begin
                        cnt_d   = cnt_q - 1'b1;
                        addr1_d = even_addr(cnt_d);
                        addr2_d = odd_addr(cnt_d);
                        state_d = ST_RD;
                    end
                end
            end

            ST_DONE: begin
                if (iReady) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            addr1_q <= '0;
            addr2_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            addr1_q <= addr1_d;
            addr2_q <= addr2_d;
        end
    end

    assign oReady      = (state_q == ST_IDLE);
    assign oValid      = (state_q == ST_DONE);
    assign oA          = a_q;
    assign oB          = b_q;
    assign oS_address1 = addr1_q;
    assign oS_address2 = addr2_q;

endmodule

// File: tb/tb_rc5_crypt_engine.sv
// tb_rc5_crypt_engine -- directed and random checks of rc5_crypt_engine for
// W/R = 32/12, 16/8 and 64/20, each with its own S-table RAM model built from
// a 16-byte all-zero key.
module tb_rc5_crypt_engine;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        valid_in [3];
    logic        mode_in  [3];
    logic        ready_in [3];
    logic [63:0] a_in     [3];
    logic [63:0] b_in     [3];
    logic [63:0] s1       [3];
    logic [63:0] s2       [3];
    logic [63:0] s_tab    [3][64];

    logic        oready [3];
    logic        ovalid [3];
    logic [63:0] oa     [3];
    logic [63:0] ob     [3];
    logic [5:0]  ad1    [3];
    logic [5:0]  ad2    [3];

    logic        oready_0, ovalid_0, oready_1, ovalid_1, oready_2, ovalid_2;
    logic [31:0] oa_0, ob_0;
    logic [15:0] oa_1, ob_1;
    logic [63:0] oa_2, ob_2;
    logic [4:0]  ad1_0, ad2_0, ad1_1, ad2_1;
    logic [5:0]  ad1_2, ad2_2;

    rc5_crypt_engine #(.W(32), .R(12)) u_dut (
        .clk(clk), .rst(rst_n), .iValid(valid_in[0]), .oReady(oready_0), .iMode(mode_in[0]),
        .iA(a_in[0][31:0]), .iB(b_in[0][31:0]), .oS_address1(ad1_0), .oS_address2(ad2_0),
        .iS_sub_i1(s1[0][31:0]), .iS_sub_i2(s2[0][31:0]), .oValid(ovalid_0),
        .iReady(ready_in[0]), .oA(oa_0), .oB(ob_0)
    );

    rc5_crypt_engine #(.W(16), .R(8)) u_dut16 (
        .clk(clk), .rst(rst_n), .iValid(valid_in[1]), .oReady(oready_1), .iMode(mode_in[1]),
        .iA(a_in[1][15:0]), .iB(b_in[1][15:0]), .oS_address1(ad1_1), .oS_address2(ad2_1),
        .iS_sub_i1(s1[1][15:0]), .iS_sub_i2(s2[1][15:0]), .oValid(ovalid_1),
        .iReady(ready_in[1]), .oA(oa_1), .oB(ob_1)
    );

    rc5_crypt_engine #(.W(64), .R(20)) u_dut64 (
        .clk(clk), .rst(rst_n), .iValid(valid_in[2]), .oReady(oready_2), .iMode(mode_in[2]),
        .iA(a_in[2]), .iB(b_in[2]), .oS_address1(ad1_2), .oS_address2(ad2_2),
        .iS_sub_i1(s1[2]), .iS_sub_i2(s2[2]), .oValid(ovalid_2),
        .iReady(ready_in[2]), .oA(oa_2), .oB(ob_2)
    );

    assign oready[0] = oready_0;  assign ovalid[0] = ovalid_0;
    assign oready[1] = oready_1;  assign ovalid[1] = ovalid_1;
    assign oready[2] = oready_2;  assign ovalid[2] = ovalid_2;
    assign oa[0] = {32'h0, oa_0}; assign ob[0] = {32'h0, ob_0};
    assign oa[1] = {48'h0, oa_1}; assign ob[1] = {48'h0, ob_1};
    assign oa[2] = oa_2;          assign ob[2] = ob_2;
    assign ad1[0] = {1'b0, ad1_0}; assign ad2[0] = {1'b0, ad2_0};
    assign ad1[1] = {1'b0, ad1_1}; assign ad2[1] = {1'b0, ad2_1};
    assign ad1[2] = ad1_2;         assign ad2[2] = ad2_2;

    // Registered S-table RAMs: data appears one clock after the address.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            s1[k] <= s_tab[k][ad1[k]];
            s2[k] <= s_tab[k][ad2[k]];
        end
    end

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int wk(input int k);
        case (k)
            0:       return 32;
            1:       return 16;
            default: return 64;
        endcase
    endfunction

    function automatic int rk(input int k);
        case (k)
            0:       return 12;
            1:       return 8;
            default: return 20;
        endcase
    endfunction

    function automatic logic [63:0] msk(input int w);
        return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] rotl(input logic [63:0] x, input logic [63:0] s, input int w);
        logic [63:0] m;
        logic [63:0] v;
        int sh;
        m  = msk(w);
        v  = x & m;
        sh = int'(s % 64'(w));
        if (sh == 0) return v;
        return ((v << sh) | (v >> (w - sh))) & m;
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] x, input logic [63:0] s, input int w);
        return rotl(x, 64'(w) - (s % 64'(w)), w);
    endfunction

    task automatic expand_key(input int k);
        int w, r, t, c, n, i, j;
        logic [63:0] m, p, q, a, b;
        logic [63:0] l [16];
        w = wk(k); r = rk(k); m = msk(w);
        t = 2 * r + 2;
        c = 16 / (w / 8);
        case (w)
            16:      begin p = 64'hB7E1;             q = 64'h9E37; end
            32:      begin p = 64'hB7E15163;         q = 64'h9E3779B9; end
            default: begin p = 64'hB7E151628AED2A6B; q = 64'h9E3779B97F4A7C15; end
        endcase
        for (int x = 0; x < 16; x++) l[x] = '0;
        for (int x = 0; x < 64; x++) s_tab[k][x] = '0;
        s_tab[k][0] = p;
        for (int x = 1; x < t; x++) s_tab[k][x] = (s_tab[k][x-1] + q) & m;
        a = '0; b = '0; i = 0; j = 0;
        n = 3 * ((t > c) ? t : c);
        for (int x = 0; x < n; x++) begin
            a = rotl(s_tab[k][i] + a + b, 64'd3, w);
            s_tab[k][i] = a;
            b = rotl(l[j] + a + b, a + b, w);
            l[j] = b;
            i = (i + 1) % t;
            j = (j + 1) % c;
        end
    endtask

    task automatic model_enc(input int k, input logic [63:0] pa, input logic [63:0] pb,
                             output logic [63:0] ca, output logic [63:0] cb);
        int w, r;
        logic [63:0] m, a, b;
        w = wk(k); r = rk(k); m = msk(w);
        a = (pa + s_tab[k][0]) & m;
        b = (pb + s_tab[k][1]) & m;
        for (int i = 1; i <= r; i++) begin
            a = (rotl(a ^ b, b, w) + s_tab[k][2*i]) & m;
            b = (rotl(b ^ a, a, w) + s_tab[k][2*i+1]) & m;
        end
        ca = a; cb = b;
    endtask

    task automatic model_dec(input int k, input logic [63:0] ca, input logic [63:0] cb,
                             output logic [63:0] pa, output logic [63:0] pb);
        int w, r;
        logic [63:0] m, a, b;
        w = wk(k); r = rk(k); m = msk(w);
        a = ca & m; b = cb & m;
        for (int i = r; i >= 1; i--) begin
            b = rotr((b - s_tab[k][2*i+1]) & m, a, w) ^ a;
            a = rotr((a - s_tab[k][2*i]) & m, b, w) ^ b;
        end
        pa = (a - s_tab[k][0]) & m;
        pb = (b - s_tab[k][1]) & m;
    endtask

    // ---------------- transaction helpers ----------------
    task automatic start_txn(input int k, input logic mode, input logic [63:0] a, input logic [63:0] b);
        int n;
        @(negedge clk);
        valid_in[k] = 1'b1; mode_in[k] = mode; a_in[k] = a; b_in[k] = b;
        n = 0;
        while (oready[k] !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        // Scramble inputs after the accept edge; the engine must ignore them.
        valid_in[k] = 1'b0; mode_in[k] = ~mode;
        a_in[k] = {$urandom, $urandom}; b_in[k] = {$urandom, $urandom};
    endtask

    task automatic wait_valid(input int k, output int lat);
        lat = 0;
        while (ovalid[k] !== 1'b1 && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic finish_txn(input int k);
        ready_in[k] = 1'b1;
        @(posedge clk);
        #1;
        ready_in[k] = 1'b0;
        check("ready_after_hs", 64'(oready[k]), 64'd1);
        check("valid_after_hs", 64'(ovalid[k]), 64'd0);
    endtask

    task automatic run_txn(input int k, input logic mode, input logic [63:0] a, input logic [63:0] b,
                           output logic [63:0] ra, output logic [63:0] rb);
        int lat;
        start_txn(k, mode, a, b);
        wait_valid(k, lat);
        check("latency", 64'(lat), 64'(3 * rk(k) + 2));
        ra = oa[k]; rb = ob[k];
        finish_txn(k);
    endtask

    task automatic check_reset_outputs(input int k);
        check("rst_ready", 64'(oready[k]), 64'd1);
        check("rst_valid", 64'(ovalid[k]), 64'd0);
        check("rst_oa", oa[k], 64'd0);
        check("rst_ob", ob[k], 64'd0);
        check("rst_addr1", 64'(ad1[k]), 64'd0);
        check("rst_addr2", 64'(ad2[k]), 64'd0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] ra, rb, pa, pb, ca, cb, ha, hb;
        int lat;

        for (int k = 0; k < 3; k++) begin
            valid_in[k] = 1'b0; mode_in[k] = 1'b0; ready_in[k] = 1'b0;
            a_in[k] = '0; b_in[k] = '0;
            expand_key(k);
        end

        // Reset state.
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) check_reset_outputs(k);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

`ifdef RC5_ENCRYPT_EN
        // Known-answer encrypt of the zero block.
        run_txn(0, 1'b1, 64'h0, 64'h0, ra, rb);
        check("kat_enc_a", ra, 64'hEEDBA521);
        check("kat_enc_b", rb, 64'h6D8F4B15);
`endif

        // Known-answer decrypt.
        run_txn(0, 1'b0, 64'hEEDBA521, 64'h6D8F4B15, ra, rb);
        check("kat_dec_a", ra, 64'h0);
        check("kat_dec_b", rb, 64'h0);

        // Result held while downstream stalls; input offers ignored meanwhile.
        start_txn(0, 1'b0, 64'hEEDBA521, 64'h6D8F4B15);
        wait_valid(0, lat);
        check("hold_latency", 64'(lat), 64'd38);
        ha = oa[0]; hb = ob[0];
        check("hold_res_a", ha, 64'h0);
        check("hold_res_b", hb, 64'h0);
        for (int c = 0; c < 10; c++) begin
            valid_in[0] = c[0];
            a_in[0] = {32'h0, $urandom}; b_in[0] = {32'h0, $urandom};
            @(posedge clk);
            #1;
            check("hold_valid", 64'(ovalid[0]), 64'd1);
            check("hold_ready", 64'(oready[0]), 64'd0);
            check("hold_a", oa[0], ha);
            check("hold_b", ob[0], hb);
        end
        valid_in[0] = 1'b0;
        finish_txn(0);
        @(posedge clk);
        #1;
        check("idle_stays_ready", 64'(oready[0]), 64'd1);
        check("idle_no_valid", 64'(ovalid[0]), 64'd0);

        // Reset in the middle of a decrypt, then a clean transaction.
        start_txn(0, 1'b0, 64'hEEDBA521, 64'h6D8F4B15);
        repeat (20) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_reset_outputs(0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_txn(0, 1'b0, 64'hEEDBA521, 64'h6D8F4B15, ra, rb);
        check("post_rst_a", ra, 64'h0);
        check("post_rst_b", rb, 64'h0);

`ifndef RC5_ENCRYPT_EN
        // Decrypt-only build: an encrypt request still decrypts.
        run_txn(0, 1'b1, 64'hEEDBA521, 64'h6D8F4B15, ra, rb);
        check("mode_forced_a", ra, 64'h0);
        check("mode_forced_b", rb, 64'h0);
`endif

        // Random round trips on every width.
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 40; n++) begin
                pa = {$urandom, $urandom} & msk(wk(k));
                pb = {$urandom, $urandom} & msk(wk(k));
                model_enc(k, pa, pb, ca, cb);
`ifdef RC5_ENCRYPT_EN
                run_txn(k, 1'b1, pa, pb, ra, rb);
                check("rand_enc_a", ra, ca);
                check("rand_enc_b", rb, cb);
                ca = ra; cb = rb;
`endif
                run_txn(k, 1'b0, ca, cb, ra, rb);
                check("rand_dec_a", ra, pa);
                check("rand_dec_b", rb, pb);
                model_dec(k, ca, cb, ha, hb);
                check("model_dec_a", ra, ha);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
